// File: rtl/pump_sequencer.sv
// -----------------------------------------------------------------------------
// pump_sequencer
// Transaction controller for one fuel pump. Latches the fuel choice, collects
// payment, converts the credit into a litre-unit quota by repeated
// subtraction, then arms and supervises the pump datapath. Completion, change
// and refunds are reported to the station front panel.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   fuel_btn    in   [2:0]  one-hot fuel choice (001/010/100 valid)
//   money       in   [23:0] payment amount, taken when money_valid=1
//   money_valid in   one-cycle payment strobe
//   confirm     in   customer confirms payment
//   cancel      in   customer aborts
//   nozzle      in   1 = nozzle lifted / in tank
//   gas         in   [2:0]  pump flow status, nonzero = flowing
//   pump_reset  out  active-low clear to the pump counter
//   start       out  pump start
//   valve       out  pump valve enable
//   lit         out  [23:0] litre-unit quota
//   select      out  [2:0]  fuel select to pump
//   busy        out  high in every state except IDLE
//   done        out  one-cycle completion pulse
//   refund      out  one-cycle refund pulse
//   change      out  [23:0] change/refund amount, valid with done or refund
// -----------------------------------------------------------------------------
module pump_sequencer #(
    parameter int unsigned PRICE1  = 25,
    parameter int unsigned PRICE2  = 23,
    parameter int unsigned PRICE4  = 20,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  fuel_btn,
    input  logic [23:0] money,
    input  logic        money_valid,
    input  logic        confirm,
    input  logic        cancel,
    input  logic        nozzle,
    input  logic [2:0]  gas,
    output logic        pump_reset,
    output logic        start,
    output logic        valve,
    output logic [23:0] lit,
    output logic [2:0]  select,
    output logic        busy,
    output logic        done,
    output logic        refund,
    output logic [23:0] change
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 32'd1);
    // A timer value of TIMER_LAST means this is the TIMEOUT-th counted cycle.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAY      = 3'd1,
        ST_CALC     = 3'd2,
        ST_ARM      = 3'd3,
        ST_DISPENSE = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Credit accumulation clamps instead of wrapping.
    function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [23:0] b);
        logic [24:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[24] ? 24'hFF_FFFF : sum[23:0];
    endfunction

    // An unknown select yields the maximum price, so the quota collapses
    // to (almost always) zero and the customer is refunded.
    function automatic logic [23:0] price_of(input logic [2:0] sel);
        case (sel)
            3'b001:  return 24'(PRICE1);
            3'b010:  return 24'(PRICE2);
            3'b100:  return 24'(PRICE4);
            default: return 24'hFF_FFFF;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    endfunction

    state_t              state_r,      state_s;
    logic [23:0]         credit_r,     credit_s;
    logic [23:0]         rem_r,        rem_s;
    logic [TIMER_W-1:0]  timer_r,      timer_s;
    logic                flow_seen_r,  flow_seen_s;
    logic                pump_reset_r, pump_reset_s;
    logic                start_r,      start_s;
    logic                valve_r,      valve_s;
    logic [23:0]         lit_r,        lit_s;
    logic [2:0]          select_r,     select_s;
    logic                busy_r,       busy_s;
    logic                done_r,       done_s;
    logic                refund_r,     refund_s;
    logic [23:0]         change_r,     change_s;
    logic [23:0]         credit_sum_s;
    logic [23:0]         price_s;

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_s      = state_r;
        credit_s     = credit_r;
        rem_s        = rem_r;
        timer_s      = timer_r;
        flow_seen_s  = flow_seen_r;
        pump_reset_s = 1'b1;
        start_s      = start_r;
        valve_s      = valve_r;
        lit_s        = lit_r;
        select_s     = select_r;
        done_s       = 1'b0;
        refund_s     = 1'b0;
        change_s     = 24'h00_0000;
        price_s      = price_of(select_r);
        if (money_valid) begin
            credit_sum_s = sat_add(credit_r, money);
        end else begin
            credit_sum_s = credit_r;
        end

        case (state_r)
            ST_IDLE: begin
                start_s = 1'b0;
                valve_s = 1'b0;
                if (is_onehot(fuel_btn)) begin
                    select_s = fuel_btn;
                    lit_s    = 24'h00_0000;
                    credit_s = 24'h00_0000;
                    rem_s    = 24'h00_0000;
                    state_s  = ST_PAY;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_PAY: begin
                // A strobe arriving with cancel is still refunded.
                if (cancel) begin
                    refund_s = 1'b1;
                    change_s = credit_sum_s;
                    credit_s = 24'h00_0000;
                    state_s  = ST_IDLE;
                end else if (confirm && (credit_sum_s != 24'h00_0000)) begin
                    credit_s = credit_sum_s;
                    rem_s    = credit_sum_s;
                    lit_s    = 24'h00_0000;
                    state_s  = ST_CALC;
                end else begin
                    credit_s = credit_sum_s;
                end
            end

            ST_CALC: begin
                if (rem_r >= price_s) begin
                    rem_s = rem_r - price_s;
                    lit_s = lit_r + 24'd1;
                end else if (lit_r == 24'h00_0000) begin
                    refund_s = 1'b1;
                    change_s = credit_r;
                    credit_s = 24'h00_0000;
                    state_s  = ST_IDLE;
                end else begin
                    // pump_reset low and start low for the first ARM cycle.
                    pump_reset_s = 1'b0;
                    start_s      = 1'b0;
                    timer_s      = '0;
                    state_s      = ST_ARM;
                end
            end

            ST_ARM: begin
                if (cancel || (!nozzle && (timer_r == TIMER_LAST))) begin
                    refund_s = 1'b1;
                    change_s = credit_r;
                    credit_s = 24'h00_0000;
                    start_s  = 1'b0;
                    timer_s  = '0;
                    state_s  = ST_IDLE;
                end else if (nozzle) begin
                    start_s     = 1'b1;
                    valve_s     = 1'b1;
                    timer_s     = '0;
                    flow_seen_s = 1'b0;
                    state_s     = ST_DISPENSE;
                end else begin
                    start_s = 1'b1;
                    timer_s = timer_r + TIMER_W'(1);
                end
            end

            ST_DISPENSE: begin
                start_s = 1'b1;
                valve_s = nozzle;
                if (gas != 3'b000) begin
                    flow_seen_s = 1'b1;
                end else begin
                    flow_seen_s = flow_seen_r;
                end
                // Flow has started and then stopped with the nozzle in the
                // tank, or the nozzle has been down for too long.
                if ((nozzle && flow_seen_r && (gas == 3'b000)) ||
                    (!nozzle && (timer_r == TIMER_LAST))) begin
                    done_s   = 1'b1;
                    change_s = rem_r;
                    start_s  = 1'b0;
                    valve_s  = 1'b0;
                    timer_s  = '0;
                    state_s  = ST_DONE;
                end else if (nozzle) begin
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + TIMER_W'(1);
                end
            end

            ST_DONE: begin
                start_s  = 1'b0;
                valve_s  = 1'b0;
                credit_s = 24'h00_0000;
                state_s  = ST_IDLE;
            end

            default: begin
                start_s  = 1'b0;
                valve_s  = 1'b0;
                credit_s = 24'h00_0000;
                timer_s  = '0;
                state_s  = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            credit_r     <= 24'h00_0000;
            rem_r        <= 24'h00_0000;
            timer_r      <= '0;
            flow_seen_r  <= 1'b0;
            pump_reset_r <= 1'b1;
            start_r      <= 1'b0;
            valve_r      <= 1'b0;
            lit_r        <= 24'h00_0000;
            select_r     <= 3'b000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            refund_r     <= 1'b0;
            change_r     <= 24'h00_0000;
        end else begin
            state_r      <= state_s;
            credit_r     <= credit_s;
            rem_r        <= rem_s;
            timer_r      <= timer_s;
            flow_seen_r  <= flow_seen_s;
            pump_reset_r <= pump_reset_s;
            start_r      <= start_s;
            valve_r      <= valve_s;
            lit_r        <= lit_s;
            select_r     <= select_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            refund_r     <= refund_s;
            change_r     <= change_s;
        end
    end

    assign pump_reset = pump_reset_r;
    assign start      = start_r;
    assign valve      = valve_r;
    assign lit        = lit_r;
    assign select     = select_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign refund     = refund_r;
    assign change     = change_r;

endmodule

// File: tb/tb_pump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pump_sequencer
// Drives whole customer transactions (directed scenarios, then random ones)
// and predicts the panel/pump outputs from the pricing rules: quota =
// credit / price, change = credit % price, quota+1 cycles of calculation,
// TIMEOUT-cycle nozzle limits.
// -----------------------------------------------------------------------------
module tb_pump_sequencer;

    localparam int TIMEOUT      = 1000;
    localparam int M_PAY_CANCEL = 0;
    localparam int M_ARM_TMO    = 1;
    localparam int M_ARM_CANCEL = 2;
    localparam int M_DISPENSE   = 3;
    localparam int M_RESET_DISP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  fuel_btn;
    logic [23:0] money;
    logic        money_valid;
    logic        confirm;
    logic        cancel;
    logic        nozzle;
    logic [2:0]  gas;
    logic        pump_reset;
    logic        start;
    logic        valve;
    logic [23:0] lit;
    logic [2:0]  select;
    logic        busy;
    logic        done;
    logic        refund;
    logic [23:0] change;

    int checks = 0;
    int errors = 0;
    int pay_q[$];
    logic [2:0] last_sel;

    pump_sequencer #(
        .PRICE1 (25),
        .PRICE2 (23),
        .PRICE4 (20),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fuel_btn   (fuel_btn),
        .money      (money),
        .money_valid(money_valid),
        .confirm    (confirm),
        .cancel     (cancel),
        .nozzle     (nozzle),
        .gas        (gas),
        .pump_reset (pump_reset),
        .start      (start),
        .valve      (valve),
        .lit        (lit),
        .select     (select),
        .busy       (busy),
        .done       (done),
        .refund     (refund),
        .change     (change)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int price_of(input logic [2:0] f);
        case (f)
            3'b001:  return 25;
            3'b010:  return 23;
            default: return 20;
        endcase
    endfunction

    function automatic int sat24(input int a, input int b);
        return (a + b > 32'hFF_FFFF) ? 32'hFF_FFFF : a + b;
    endfunction

    // done and refund must never overlap
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check_eq("done_refund_excl", 32'(done & refund), 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pump_reset"}, 32'(pump_reset), 32'd1);
        check_eq({tag, "_start"},      32'(start),      32'd0);
        check_eq({tag, "_valve"},      32'(valve),      32'd0);
        check_eq({tag, "_lit"},        32'(lit),        32'd0);
        check_eq({tag, "_select"},     32'(select),     32'd0);
        check_eq({tag, "_busy"},       32'(busy),       32'd0);
        check_eq({tag, "_done"},       32'(done),       32'd0);
        check_eq({tag, "_refund"},     32'(refund),     32'd0);
        check_eq({tag, "_change"},     32'(change),     32'd0);
    endtask

    task automatic expect_refund(input string tag, input int amount);
        check_eq({tag, "_refund"}, 32'(refund), 32'd1);
        check_eq({tag, "_change"}, 32'(change), 32'(amount));
        check_eq({tag, "_busy"},   32'(busy),   32'd0);
        check_eq({tag, "_start"},  32'(start),  32'd0);
        tick();
        check_eq({tag, "_refund_end"}, 32'(refund), 32'd0);
    endtask

    // One complete customer transaction; payments come from pay_q.
    task automatic run_txn(input logic [2:0] fuel, input int mode,
                           input int pause_len, input int conf_money);
        int credit_m;
        int exp_lit;
        int exp_rem;
        int n;
        int flow;
        fuel_btn = fuel;
        tick();
        fuel_btn = 3'b000;
        last_sel = fuel;
        check_eq("pay_busy", 32'(busy), 32'd1);
        check_eq("pay_select", 32'(select), 32'(fuel));
        credit_m = 0;
        foreach (pay_q[i]) begin
            money = 24'(pay_q[i]);
            money_valid = 1'b1;
            tick();
            money_valid = 1'b0;
            credit_m = sat24(credit_m, pay_q[i]);
        end
        if (mode == M_PAY_CANCEL) begin
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            expect_refund("pay_cancel", credit_m);
            return;
        end
        confirm = 1'b1;
        money = 24'(conf_money);
        money_valid = (conf_money > 0);
        tick();
        confirm = 1'b0;
        money_valid = 1'b0;
        credit_m = sat24(credit_m, conf_money);
        if (credit_m == 0) begin
            tick();
            tick();
            check_eq("zero_confirm_busy", 32'(busy), 32'd1);
            check_eq("zero_confirm_refund", 32'(refund), 32'd0);
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            expect_refund("zero_cancel", 0);
            return;
        end
        exp_lit = credit_m / price_of(fuel);
        exp_rem = credit_m % price_of(fuel);
        n = 0;
        do begin
            tick();
            n++;
        end while (pump_reset == 1'b1 && refund == 1'b0 && n < 5000);
        check_eq("calc_latency", 32'(n), 32'(exp_lit + 1));
        if (exp_lit == 0) begin
            expect_refund("calc_zero", credit_m);
            return;
        end
        check_eq("arm_lit", 32'(lit), 32'(exp_lit));
        check_eq("arm_pump_reset_lo", 32'(pump_reset), 32'd0);
        check_eq("arm_start_first", 32'(start), 32'd0);
        check_eq("arm_busy", 32'(busy), 32'd1);
        tick();
        check_eq("arm_pump_reset_hi", 32'(pump_reset), 32'd1);
        check_eq("arm_start", 32'(start), 32'd1);
        if (mode == M_ARM_TMO) begin
            n = 2;
            while (refund == 1'b0 && n < TIMEOUT + 10) begin
                tick();
                n++;
            end
            check_eq("arm_timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
            expect_refund("arm_timeout", credit_m);
            return;
        end
        if (mode == M_ARM_CANCEL) begin
            repeat ($urandom_range(0, 3)) tick();
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            expect_refund("arm_cancel", credit_m);
            return;
        end
        repeat ($urandom_range(0, 3)) tick();
        nozzle = 1'b1;
        tick();
        check_eq("disp_start", 32'(start), 32'd1);
        check_eq("disp_valve", 32'(valve), 32'd1);
        flow = exp_lit * 5;
        for (int i = 0; i < flow; i++) begin
            if (mode == M_RESET_DISP && i == 2) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("rst_async");
                tick();
                check_reset_outputs("rst_hold");
                reset = 1'b1;
                nozzle = 1'b0;
                gas = 3'b000;
                last_sel = 3'b000;
                tick();
                check_eq("rst_after_busy", 32'(busy), 32'd0);
                check_eq("rst_after_done", 32'(done), 32'd0);
                check_eq("rst_after_refund", 32'(refund), 32'd0);
                return;
            end
            if (pause_len > 0 && i == flow / 2) begin
                nozzle = 1'b0;
                gas = 3'b000;
                if (pause_len >= TIMEOUT) begin
                    n = 0;
                    do begin
                        tick();
                        n++;
                    end while (done == 1'b0 && n < TIMEOUT + 10);
                    check_eq("pause_timeout_cycles", 32'(n), 32'(TIMEOUT));
                    check_eq("pause_done", 32'(done), 32'd1);
                    check_eq("pause_change", 32'(change), 32'(exp_rem));
                    check_eq("pause_valve", 32'(valve), 32'd0);
                    tick();
                    check_eq("pause_done_end", 32'(done), 32'd0);
                    check_eq("pause_busy_end", 32'(busy), 32'd0);
                    return;
                end
                repeat (pause_len) tick();
                check_eq("pause_valve_off", 32'(valve), 32'd0);
                check_eq("pause_no_done", 32'(done), 32'd0);
                check_eq("pause_busy", 32'(busy), 32'd1);
                nozzle = 1'b1;
            end
            gas = 3'($urandom_range(1, 7));
            tick();
            check_eq("flow_no_done", 32'(done), 32'd0);
            check_eq("flow_valve", 32'(valve), 32'd1);
        end
        gas = 3'b000;
        tick();
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_change", 32'(change), 32'(exp_rem));
        check_eq("done_start", 32'(start), 32'd0);
        check_eq("done_valve", 32'(valve), 32'd0);
        check_eq("done_refund", 32'(refund), 32'd0);
        nozzle = 1'b0;
        tick();
        check_eq("done_end", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_lit_hold", 32'(lit), 32'(exp_lit));
        check_eq("idle_select_hold", 32'(select), 32'(fuel));
    endtask

    initial begin
        logic [2:0] f;
        logic [2:0] bad;
        int r;
        int mode;
        int pause;
        int conf;
        reset = 1'b0;
        fuel_btn = 3'b000;
        money = 24'h0;
        money_valid = 1'b0;
        confirm = 1'b0;
        cancel = 1'b0;
        nozzle = 1'b0;
        gas = 3'b000;
        last_sel = 3'b000;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();
        check_eq("idle_after_reset", 32'(busy), 32'd0);

        // 001 / 100 -> quota 4, change 0
        pay_q = '{100};
        run_txn(3'b001, M_DISPENSE, 0, 0);
        // invalid fuel code is ignored
        fuel_btn = 3'b011;
        tick();
        fuel_btn = 3'b000;
        check_eq("invalid_busy", 32'(busy), 32'd0);
        check_eq("invalid_select", 32'(select), 32'(last_sel));
        // 100 / 50+15 -> quota 3, change 5
        pay_q = '{50, 15};
        run_txn(3'b100, M_DISPENSE, 0, 0);
        // 010 / 10 -> no quota, refund 10
        pay_q = '{10};
        run_txn(3'b010, M_DISPENSE, 0, 0);
        // 130 credit, nozzle never lifted
        pay_q = '{130};
        run_txn(3'b001, M_ARM_TMO, 0, 0);
        // short pause mid-flow, then a pause reaching TIMEOUT
        pay_q = '{200};
        run_txn(3'b010, M_DISPENSE, 500, 0);
        pay_q = '{100};
        run_txn(3'b100, M_DISPENSE, TIMEOUT, 0);
        // saturation, refunded
        pay_q = '{24'hF0_0000, 24'hF0_0000};
        run_txn(3'b010, M_PAY_CANCEL, 0, 0);
        // money strobe together with confirm; confirm with no credit
        pay_q = {};
        run_txn(3'b001, M_DISPENSE, 0, 50);
        pay_q = {};
        run_txn(3'b100, M_DISPENSE, 0, 0);
        // cancel in ARM, reset mid-dispense
        pay_q = '{90};
        run_txn(3'b001, M_ARM_CANCEL, 0, 0);
        pay_q = '{60};
        run_txn(3'b001, M_RESET_DISP, 0, 0);

        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 2))
                0:       f = 3'b001;
                1:       f = 3'b010;
                default: f = 3'b100;
            endcase
            bad = 3'($urandom_range(0, 7));
            if (bad != 3'b001 && bad != 3'b010 && bad != 3'b100) begin
                fuel_btn = bad;
                tick();
                fuel_btn = 3'b000;
                check_eq("rand_invalid_busy", 32'(busy), 32'd0);
                check_eq("rand_invalid_select", 32'(select), 32'(last_sel));
            end
            pay_q.delete();
            repeat ($urandom_range(0, 3)) pay_q.push_back($urandom_range(0, 150));
            r = $urandom_range(0, 9);
            if (r < 2)       mode = M_PAY_CANCEL;
            else if (r == 2) mode = M_ARM_CANCEL;
            else if (r == 3) mode = M_ARM_TMO;
            else             mode = M_DISPENSE;
            pause = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            conf  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
            run_txn(f, mode, pause, conf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pump_sequencer.md
Name: pump_sequencer

Overview:
Transaction controller for one fuel pump in the automatic gas station. Latches the fuel-type choice and accumulates payment. Converts credit to a litre-unit quota by multi-cycle subtraction. Then arms, runs and monitors the pump datapath (start/valve/lit/select/reset in, gas out), reporting completion, change and refunds to the station front panel.

Parameters:
PRICE1, 25, money units per litre-unit for fuel select 3'b001
PRICE2, 23, money units per litre-unit for fuel select 3'b010
PRICE4, 20, money units per litre-unit for fuel select 3'b100
TIMEOUT, 1000, cycles allowed waiting for nozzle (ARM) or with nozzle dropped (DISPENSE)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
fuel_btn  in  3  one-hot fuel choice; only 001/010/100 valid
money  in  24  payment amount, sampled when money_valid=1
money_valid  in  1  one-cycle payment strobe
confirm  in  1  customer confirms payment
cancel  in  1  customer aborts
nozzle  in  1  1 = nozzle lifted/in tank
gas  in  3  pump gas-flow status (nonzero = flowing)
pump_reset  out  1  active-low clear to pump counter
start  out  1  pump start
valve  out  1  pump valve enable
lit  out  24  litre-unit quota to pump
select  out  3  fuel select to pump
busy  out  1  1 in any state except IDLE
done  out  1  one-cycle completion pulse
refund  out  1  one-cycle refund pulse
change  out  24  change/refund amount, valid with done or refund

Behaviour:
- Reset (async, reset=0): state=IDLE. start=0, valve=0, lit=0, select=0, busy=0, done=0, refund=0, change=0, pump_reset=1. Credit, remainder and timers are cleared. Reset mid-transaction discards credit with no refund pulse.
- States: IDLE, PAY, CALC, ARM, DISPENSE, DONE. All outputs are registered.
- IDLE: a valid one-hot fuel_btn latches select and moves to PAY. Invalid codes, including 0, are ignored.
- PAY: money_valid adds money to credit, saturating at 24'hFFFFFF.
  - confirm with credit>0 -> CALC; confirm with credit=0 is ignored.
  - cancel -> IDLE with refund=1 and change=credit for one cycle.
  - cancel has priority over confirm. money_valid in the same cycle as confirm is added before CALC.
- CALC: price comes from select. rem is loaded with credit and lit is cleared on entry.
  - Each cycle with rem>=price: rem-=price, lit+=1.
  - When rem<price: if lit=0 -> IDLE with refund, change=credit; else -> ARM.
  - Latency = lit+1 cycles.
- ARM: pump_reset=0 for exactly the first cycle, then 1. start=1 from the second cycle.
  - nozzle=1 -> DISPENSE.
  - TIMEOUT cycles without nozzle -> IDLE with refund, change=credit.
  - cancel -> same refund.
- DISPENSE: start=1, valve=nozzle. A flag records the first gas!=0.
  - After the flag is set, gas==0 with nozzle=1 -> DONE.
  - nozzle=0 pauses dispensing and runs the pause timer; the timer restarts on every nozzle drop. Pause reaching TIMEOUT -> DONE.
  - cancel is ignored in DISPENSE.
- DONE: one cycle. done=1, change=rem, start=0, valve=0; then -> IDLE. lit and select hold their values until the next IDLE->PAY.
- done and refund are never asserted in the same cycle.

Test Plan:
- Reset mid-DISPENSE -> all outputs at reset values next edge, state IDLE, no done/refund pulse.
- fuel_btn=001, money=100 strobe, confirm -> CALC 5 cycles, lit=4, ARM pulses pump_reset low 1 cycle. Nozzle up, pump gas flows 4*5 cycles then 0 -> done=1, change=0.
- fuel_btn=100, money=50 then 15, confirm -> lit=3, change=5 on done. fuel_btn=011 in IDLE -> stays IDLE.
- fuel_btn=010, money=10, confirm -> lit=0 -> refund=1, change=10, back to IDLE, no pump activity.
- Confirm with credit=130, nozzle never lifted -> after TIMEOUT cycles refund=1, change=130.
- Nozzle dropped for 500 cycles mid-flow, lifted again -> flow resumes, done only when gas returns 0. Dropped >=TIMEOUT -> done with change=rem. Credit saturation: two strobes of 24'hF00000 -> credit=24'hFFFFFF.
